// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// The parity variant of the receiver is selected with SIPO_RX_PARITY_EN.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Counter must hold the value N, reached after the last data bit.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Enabled right-shift register: new bits enter at the MSB so the first bit
// received ends up in bit 0. Synchronous clear has priority over shifting.
module sipo_shift_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[N-1:1]};
        end
    end

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver: start bit, N data bits LSB first, optional even
// parity bit (SIPO_RX_PARITY_EN), stop bit; word presented on valid/ready.
module sipo_frame_receiver
    import sipo_rx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sin,
    output logic [N-1:0] q,
    output logic         valid,
    input  logic         ready,
    output logic         frame_err,
    output logic         overrun,
    input  logic         clr_err,
    output logic         busy
);

    localparam int CW = cnt_width(N);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shreg;
    logic          shift_clr;
    logic          shift_en;
    logic          good;

    assign shift_clr = en && (state == IDLE) && (sin == START_LEVEL);
    assign shift_en  = en && (state == DATA);
    assign busy      = (state != IDLE);

`ifdef SIPO_RX_PARITY_EN
    logic par_ok;
    assign good = (sin == IDLE_LEVEL) && par_ok;
`else
    assign good = (sin == IDLE_LEVEL);
`endif

    sipo_shift_core #(
        .N(N)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .clr (shift_clr),
        .din (sin),
        .q   (shreg)
    );

    // Error clear and handshake are applied first so that a completing frame
    // later in the block overrides them on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par_ok    <= 1'b1;
`endif
        end else begin
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (en) begin
                case (state)
                    IDLE: begin
                        if (sin == START_LEVEL) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
`ifdef SIPO_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SIPO_RX_PARITY_EN
                    PARITY: begin
                        par_ok <= (sin == ^shreg);
                        state  <= STOP;
                    end
`endif
                    STOP: begin
                        state <= IDLE;
                        if (good) begin
                            if (!valid || ready) begin
                                q     <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Self-checking bench for sipo_frame_receiver: frame-level reference model
// compared every cycle, plus hand-computed expectations from directed frames.
module tb_sipo_frame_receiver;

    localparam int N = 4;
`ifdef SIPO_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Enabled bits that follow the start bit: data, optional parity, stop.
    localparam int FRAME_BITS = N + 1 + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sin;
    logic         ready;
    logic         clr_err;
    logic [N-1:0] q;
    logic         valid;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_receiver #(
        .N(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sin       (sin),
        .q         (q),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    // Reference model: gathers enabled line samples into a frame and judges
    // the whole frame once its last bit arrives.
    bit           m_inframe = 1'b0;
    bit           m_bits[$];
    logic [N-1:0] m_q       = '0;
    bit           m_valid   = 1'b0;
    bit           m_ferr    = 1'b0;
    bit           m_ovr     = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        logic [N-1:0] w;
        bit           done;
        bit           old_valid;
        bit           frame_ok;
        if (!rst) begin
            m_inframe = 1'b0;
            m_bits.delete();
            m_q       = '0;
            m_valid   = 1'b0;
            m_ferr    = 1'b0;
            m_ovr     = 1'b0;
        end else begin
            done      = 1'b0;
            old_valid = m_valid;
            if (en === 1'b1) begin
                if (!m_inframe) begin
                    if (sin === 1'b0) begin
                        m_inframe = 1'b1;
                        m_bits.delete();
                    end
                end else begin
                    m_bits.push_back(sin);
                    if (m_bits.size() == FRAME_BITS) begin
                        done      = 1'b1;
                        m_inframe = 1'b0;
                    end
                end
            end
            if (clr_err === 1'b1) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (old_valid && ready === 1'b1) begin
                m_valid = 1'b0;
            end
            if (done) begin
                w = '0;
                for (int i = 0; i < N; i++) begin
                    w[i] = m_bits[i];
                end
                frame_ok = m_bits[FRAME_BITS-1] && (!PAR || (m_bits[N] == ^w));
                if (frame_ok) begin
                    if (!old_valid || ready === 1'b1) begin
                        m_q     = w;
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process, well away from both clock edges.
    always begin
        @(posedge clk);
        #3;
        if (check_en) begin
            checkOutput("model_q", 32'(q), 32'(m_q));
            checkOutput("model_valid", 32'(valid), 32'(m_valid));
            checkOutput("model_frame_err", 32'(frame_err), 32'(m_ferr));
            checkOutput("model_overrun", 32'(overrun), 32'(m_ovr));
            checkOutput("model_busy", 32'(busy), 32'(m_inframe));
        end
    end

    task automatic applyStimulus(input logic b, input logic e, input logic rdy, input logic clr);
        @(negedge clk);
        sin     = b;
        en      = e;
        ready   = rdy;
        clr_err = clr;
    endtask

    task automatic sendFrame(input logic [N-1:0] data, input logic stop_bit, input logic par_bit,
                             input logic rdy_at_stop, input logic clr_at_stop);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            applyStimulus(data[i], 1'b1, 1'b0, 1'b0);
        end
        if (PAR) begin
            applyStimulus(par_bit, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(stop_bit, 1'b1, rdy_at_stop, clr_at_stop);
    endtask

    function automatic logic evenPar(input logic [N-1:0] d);
        return ^d;
    endfunction

    initial begin : stimulus
        bit frame_q[$];
        rst     = 1'b0;
        en      = 1'b0;
        sin     = 1'b1;
        ready   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_q", 32'(q), 32'h0);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst      = 1'b1;
        check_en = 1'b1;

        // Line 0,1,0,1,1,1 -> 4'b1101, held until ready.
        sendFrame(4'b1101, 1'b1, evenPar(4'b1101), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("good_q", 32'(q), 32'hD);
        checkOutput("good_valid", 32'(valid), 32'h1);
        checkOutput("good_busy_done", 32'(busy), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_q", 32'(q), 32'hD);
        checkOutput("hold_valid", 32'(valid), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_valid", 32'(valid), 32'h0);
        checkOutput("drain_q_kept", 32'(q), 32'hD);

        // Bad stop bit from a clean reset.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sendFrame(4'b1101, 1'b0, evenPar(4'b1101), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("badstop_frame_err", 32'(frame_err), 32'h1);
        checkOutput("badstop_valid", 32'(valid), 32'h0);
        checkOutput("badstop_q", 32'(q), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_frame_err", 32'(frame_err), 32'h0);
        // A new error on the clearing edge wins.
        sendFrame(4'h2, 1'b0, evenPar(4'h2), 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_vs_err", 32'(frame_err), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back frames, consumer stalled: second word dropped.
        sendFrame(4'hA, 1'b1, evenPar(4'hA), 1'b0, 1'b0);
        sendFrame(4'h3, 1'b1, evenPar(4'h3), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_stall_q", 32'(q), 32'hA);
        checkOutput("b2b_stall_overrun", 32'(overrun), 32'h1);
        checkOutput("b2b_stall_valid", 32'(valid), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_cleared_overrun", 32'(overrun), 32'h0);
        checkOutput("b2b_cleared_valid", 32'(valid), 32'h0);

        // Same pair, consumer accepts on the second stop edge.
        sendFrame(4'hA, 1'b1, evenPar(4'hA), 1'b0, 1'b0);
        sendFrame(4'h3, 1'b1, evenPar(4'h3), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_accept_q", 32'(q), 32'h3);
        checkOutput("b2b_accept_overrun", 32'(overrun), 32'h0);
        checkOutput("b2b_accept_valid", 32'(valid), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

        // Bit strobe with a dead cycle after every bit.
        frame_q.push_back(1'b0);
        for (int i = 0; i < N; i++) begin
            frame_q.push_back(i == 1 || i == 2);
        end
        if (PAR) begin
            frame_q.push_back(evenPar(4'h6));
        end
        frame_q.push_back(1'b1);
        foreach (frame_q[i]) begin
            applyStimulus(frame_q[i], 1'b1, 1'b0, 1'b0);
            applyStimulus(frame_q[i], 1'b0, 1'b0, 1'b0);
            if (i == 2) begin
                checkOutput("gap_busy", 32'(busy), 32'h1);
            end
        end
        checkOutput("gap_q", 32'(q), 32'h6);
        checkOutput("gap_valid", 32'(valid), 32'h1);
        checkOutput("gap_busy_done", 32'(busy), 32'h0);

        // Reset after the second data bit of a frame.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'h0);
        checkOutput("midreset_valid", 32'(valid), 32'h0);
        checkOutput("midreset_q", 32'(q), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        sendFrame(4'h5, 1'b1, evenPar(4'h5), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("postreset_q", 32'(q), 32'h5);
        checkOutput("postreset_valid", 32'(valid), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

`ifdef SIPO_RX_PARITY_EN
        // 4'b0111 has three ones, so the even parity bit is 1.
        sendFrame(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("par_good_valid", 32'(valid), 32'h1);
        checkOutput("par_good_q", 32'(q), 32'h7);
        checkOutput("par_good_frame_err", 32'(frame_err), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        sendFrame(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("par_bad_frame_err", 32'(frame_err), 32'h1);
        checkOutput("par_bad_valid", 32'(valid), 32'h0);
`endif

        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
